// File: rtl/sseg_scan_n.sv
// sseg_scan_n: N-digit multiplexed seven-segment driver with a serial
// double-dabble BCD converter, scan prescaler, blanking, sign, dp and blink.
module sseg_scan_n #(
   parameter int NDIG        = 4,
   parameter int WIDTH       = 14,
   parameter int DIV         = 50000,
   parameter int BLINK_TICKS = 256,
   localparam int SW = NDIG > 2 ? $clog2(NDIG) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] value,
   input  logic             sign,
   input  logic             load,
   input  logic             valid,
   input  logic             dp_en,
   input  logic [SW-1:0]    dp_sel,
   input  logic             blank_lz,
   input  logic             blink_en,
   output logic [7:0]       ssegs,
   output logic [NDIG-1:0]  disp_en,
   output logic             busy
);
   localparam int NBCD = 3 * WIDTH / 10 + 1;
   localparam int BW   = 4 * NBCD;
   localparam int ND   = NDIG < NBCD ? NDIG : NBCD;
   localparam int CW   = $clog2(WIDTH + 1);
   localparam int PW   = $clog2(DIV);
   localparam int KW   = BLINK_TICKS > 1 ? $clog2(BLINK_TICKS) : 1;
   localparam logic [7:0] DASH = 8'hFD;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t            state_q, state_d;
   logic [WIDTH-1:0]  bin_q, bin_d;
   logic [BW-1:0]     bcd_q, bcd_d, adj;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              sgn_cap_q, sgn_cap_d, busy_q, busy_d;
   logic [4*NDIG-1:0] disp_q, disp_d;
   logic              sign_q, sign_d, ovf_q, ovf_d, ovf;
   logic [PW-1:0]     pre_q, pre_d;
   logic [SW-1:0]     idx_q, idx_d, msd;
   logic [KW-1:0]     bc_q, bc_d;
   logic              ph_q, ph_d, tick, dp_on;
   logic [7:0]        ssegs_q, ssegs_d, code;
   logic [NDIG-1:0]   en_q, en_d;
   logic [3:0]        dig;

   function automatic logic [7:0] seg7(input logic [3:0] d);
      case (d)
         4'd0: return 8'h03;
         4'd1: return 8'h9F;
         4'd2: return 8'h25;
         4'd3: return 8'h0D;
         4'd4: return 8'h99;
         4'd5: return 8'h49;
         4'd6: return 8'h41;
         4'd7: return 8'h1F;
         4'd8: return 8'h01;
         4'd9: return 8'h09;
         default: return 8'hFF;
      endcase
   endfunction

   always_comb begin
      state_d = state_q;
      bin_d = bin_q;
      bcd_d = bcd_q;
      cnt_d = cnt_q;
      sgn_cap_d = sgn_cap_q;
      busy_d = busy_q;
      disp_d = disp_q;
      sign_d = sign_q;
      ovf_d = ovf_q;
      adj = bcd_q;
      for (int i = 0; i < NBCD; i++)
         if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      // a signed value gives up the top digit to the dash
      ovf = 1'b0;
      for (int i = 0; i < NBCD; i++)
         if (bcd_q[4*i +: 4] != 4'd0 && i >= NDIG - (sgn_cap_q ? 1 : 0)) ovf = 1'b1;
      case (state_q)
         IDLE: if (load) begin
            state_d = SHIFT;
            bin_d = value;
            bcd_d = '0;
            cnt_d = '0;
            sgn_cap_d = sign;
            busy_d = 1'b1;
         end
         SHIFT: begin
            bcd_d = {adj[BW-2:0], bin_q[WIDTH-1]};
            bin_d = bin_q << 1;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) state_d = DONE;
         end
         default: begin
            state_d = IDLE;
            busy_d = 1'b0;
            sign_d = sgn_cap_q;
            ovf_d = ovf;
            disp_d = '0;
            for (int i = 0; i < ND; i++) disp_d[4*i +: 4] = bcd_q[4*i +: 4];
         end
      endcase
      tick = pre_q == PW'(DIV - 1);
      pre_d = tick ? '0 : pre_q + PW'(1);
      idx_d = tick ? (idx_q == SW'(NDIG - 1) ? '0 : idx_q + SW'(1)) : idx_q;
      bc_d = tick ? (bc_q == KW'(BLINK_TICKS - 1) ? '0 : bc_q + KW'(1)) : bc_q;
      ph_d = tick && bc_q == KW'(BLINK_TICKS - 1) ? ~ph_q : ph_q;
      msd = '0;
      for (int i = 1; i < NDIG; i++)
         if (disp_q[4*i +: 4] != 4'd0) msd = SW'(i);
      dig = disp_q[{idx_q, 2'b00} +: 4];
      code = !valid || ovf_q ? DASH
           : sign_q && !blank_lz && idx_q == SW'(NDIG - 1) ? DASH
           : sign_q && blank_lz && {1'b0, idx_q} == {1'b0, msd} + (SW+1)'(1) ? DASH
           : blank_lz && idx_q > msd ? 8'hFF
           : seg7(dig);
      dp_on = dp_en && dp_sel == idx_q && valid && !ovf_q;
      ssegs_d = {code[7:1], ~dp_on};
      en_d = blink_en && !ph_q ? '1 : ~(NDIG'(1) << idx_q);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         bin_q <= '0;
         bcd_q <= '0;
         cnt_q <= '0;
         sgn_cap_q <= 1'b0;
         busy_q <= 1'b0;
         disp_q <= '0;
         sign_q <= 1'b0;
         ovf_q <= 1'b0;
         pre_q <= '0;
         idx_q <= '0;
         bc_q <= '0;
         ph_q <= 1'b1;
         ssegs_q <= 8'hFF;
         en_q <= '1;
      end else begin
         state_q <= state_d;
         bin_q <= bin_d;
         bcd_q <= bcd_d;
         cnt_q <= cnt_d;
         sgn_cap_q <= sgn_cap_d;
         busy_q <= busy_d;
         disp_q <= disp_d;
         sign_q <= sign_d;
         ovf_q <= ovf_d;
         pre_q <= pre_d;
         idx_q <= idx_d;
         bc_q <= bc_d;
         ph_q <= ph_d;
         ssegs_q <= ssegs_d;
         en_q <= en_d;
      end
   end

   assign ssegs = ssegs_q;
   assign disp_en = en_q;
   assign busy = busy_q;
endmodule

// File: tb/tb_sseg_scan_n.sv
// tb_sseg_scan_n: randomized and directed checks of sseg_scan_n against a
// decimal-arithmetic model of the display.
module tb_sseg_scan_n;
   localparam int NDIG = 4, WIDTH = 14, DIV = 4, BT = 2;

   logic clk = 0, rst = 1;
   logic [WIDTH-1:0] value = '0;
   logic sign = 0, load = 0, valid = 1, dp_en = 0, blank_lz = 0, blink_en = 0;
   logic [1:0] dp_sel = '0;
   logic [7:0] ssegs;
   logic [NDIG-1:0] disp_en;
   logic busy;

   int compared = 0, mismatched = 0;

   sseg_scan_n #(.NDIG(NDIG), .WIDTH(WIDTH), .DIV(DIV), .BLINK_TICKS(BT)) dut (
      .clk(clk), .rst(rst), .value(value), .sign(sign), .load(load), .valid(valid),
      .dp_en(dp_en), .dp_sel(dp_sel), .blank_lz(blank_lz), .blink_en(blink_en),
      .ssegs(ssegs), .disp_en(disp_en), .busy(busy));

   always #5 clk = ~clk;

   logic [7:0] segt [0:9] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F, 8'h01, 8'h09};

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // what digit i must show for a displayed value v and sign s
   function automatic logic [7:0] exp_seg(int v, bit s, int i, bit vld, bit blz, bit dpe, int dps);
      int p = 1, lim = 1, top = 0, t = v;
      bit ovf, dpo;
      logic [7:0] c;
      repeat (i) p *= 10;
      repeat (s ? NDIG - 1 : NDIG) lim *= 10;
      while (t >= 10) begin t /= 10; top++; end
      ovf = v >= lim;
      if (!vld || ovf) c = 8'hFD;
      else if (s && !blz && i == NDIG - 1) c = 8'hFD;
      else if (s && blz && i == top + 1) c = 8'hFD;
      else if (blz && i > top) c = 8'hFF;
      else c = segt[(v / p) % 10];
      dpo = dpe && dps == i && vld && !ovf;
      return {c[7:1], !dpo};
   endfunction

   int n, mval, pv, busy_cnt;
   bit msgn, ps;
   logic [7:0] exp_ss = 8'hFF;
   logic [NDIG-1:0] exp_en = '1;
   logic exp_busy = 0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         n = 0; mval = 0; msgn = 0; busy_cnt = 0;
         exp_ss = 8'hFF; exp_en = '1; exp_busy = 0;
      end else begin
         exp_ss = exp_seg(mval, msgn, (n / DIV) % NDIG, valid, blank_lz, dp_en, int'(dp_sel));
         exp_en = blink_en && ((n / DIV / BT) % 2 == 1) ? '1 : ~(4'b0001 << ((n / DIV) % NDIG));
         if (busy_cnt == 0) begin
            if (load) begin pv = int'(value); ps = sign; busy_cnt = WIDTH + 1; end
         end else begin
            busy_cnt--;
            if (busy_cnt == 0) begin mval = pv; msgn = ps; end
         end
         exp_busy = busy_cnt != 0;
         n++;
      end
   end

   always @(posedge clk) begin
      #1;
      chk("ssegs", ssegs, exp_ss);
      chk("disp_en", disp_en, exp_en);
      chk("busy", busy, exp_busy);
   end

   task automatic slot(input int i, input logic [7:0] want, input string nm);
      int k = 0;
      logic [3:0] tgt = ~(4'b0001 << i);
      @(negedge clk);
      while (disp_en !== tgt && k < 40) begin @(negedge clk); k++; end
      if (k >= 40) begin
         compared++; mismatched++;
         $display("FAIL %s: slot %0d never scanned", nm, i);
      end else chk(nm, ssegs, want);
   endtask

   task automatic do_load(input int v, input bit s);
      @(negedge clk); value = WIDTH'(v); sign = s; load = 1;
      @(negedge clk); load = 0;
   endtask

   task automatic wait_idle(output int cyc);
      cyc = 0;
      while (busy && cyc < 40) begin @(negedge clk); cyc++; end
   endtask

   initial begin
      int cyc, r;
      repeat (3) @(negedge clk);
      chk("rst_ssegs", ssegs, 8'hFF);
      chk("rst_en", disp_en, 4'hF);
      rst = 0;
      @(negedge clk);
      chk("first_en", disp_en, 4'b1110);
      chk("first_seg", ssegs, 8'h03);
      chk("first_busy", busy, 1'b0);
      do_load(1234, 0); wait_idle(cyc);
      chk("busy_len", cyc, 15);
      slot(0, 8'h99, "d1234_0"); slot(1, 8'h0D, "d1234_1");
      slot(2, 8'h25, "d1234_2"); slot(3, 8'h9F, "d1234_3");
      blank_lz = 1;
      do_load(42, 1); wait_idle(cyc);
      slot(0, 8'h25, "m42_0"); slot(1, 8'h99, "m42_1");
      slot(2, 8'hFD, "m42_2"); slot(3, 8'hFF, "m42_3");
      @(negedge clk); blank_lz = 0;
      slot(3, 8'hFD, "m42nb_3"); slot(2, 8'h03, "m42nb_2");
      do_load(9999, 0); wait_idle(cyc);
      slot(0, 8'h09, "d9999_0"); slot(3, 8'h09, "d9999_3");
      do_load(12345, 0); wait_idle(cyc);
      slot(0, 8'hFD, "ovf_0"); slot(3, 8'hFD, "ovf_3");
      do_load(1000, 1); wait_idle(cyc);
      slot(0, 8'hFD, "sovf_0"); slot(2, 8'hFD, "sovf_2");
      blank_lz = 1; dp_en = 1; dp_sel = 2;
      do_load(7, 0); wait_idle(cyc);
      slot(2, 8'hFE, "dp_2"); slot(0, 8'h1F, "dp_0");
      slot(1, 8'hFF, "dp_1"); slot(3, 8'hFF, "dp_3");
      @(negedge clk); valid = 0;
      slot(2, 8'hFD, "inv_2"); slot(0, 8'hFD, "inv_0");
      @(negedge clk); valid = 1; dp_en = 0; blank_lz = 0;
      do_load(1234, 0);
      repeat (2) @(negedge clk);
      value = 14'd5678; load = 1;
      @(negedge clk); load = 0;
      wait_idle(cyc);
      slot(0, 8'h99, "ign_0"); slot(3, 8'h9F, "ign_3");
      do_load(5678, 0);
      repeat (3) @(negedge clk);
      rst = 1;
      @(negedge clk); rst = 0;
      chk("abort_busy", busy, 1'b0);
      slot(3, 8'h03, "abort_3"); slot(0, 8'h03, "abort_0");
      blink_en = 1;
      r = 0;
      while (disp_en !== 4'hF && r < 40) begin @(negedge clk); r++; end
      r = 0;
      while (disp_en === 4'hF && r < 40) begin @(negedge clk); r++; end
      chk("blink_off_len", r, 8);
      r = 0;
      while (disp_en !== 4'hF && r < 40) begin @(negedge clk); r++; end
      chk("blink_on_len", r, 8);
      blink_en = 0;
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         load = $urandom_range(0, 7) == 0;
         value = $urandom_range(0, 1) ? WIDTH'($urandom_range(0, 120)) : WIDTH'($urandom_range(0, 16383));
         sign = $urandom_range(0, 1);
         if ($urandom_range(0, 20) == 0) valid = ~valid;
         if ($urandom_range(0, 10) == 0) blank_lz = ~blank_lz;
         if ($urandom_range(0, 10) == 0) dp_en = ~dp_en;
         if ($urandom_range(0, 10) == 0) dp_sel = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 30) == 0) blink_en = ~blink_en;
      end
      load = 0;
      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
